// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the fetch/data SRAM port arbiter: owner encoding and bus widths.
package sram_port_arbiter_pkg;

  // Owner of the response cycle that follows a granted SRAM access
  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DREAD  = 2'd2,
    OWN_DWRITE = 2'd3
  } owner_t;

  localparam int WE_BUS        = 4;
  localparam int INST_ADDR_BUS = 32;
  localparam int DATA_ADDR_BUS = 32;

endpackage

// File: rtl/sram_port_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access,
// data first, and routes the one-cycle-late read data back to its owner.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DATA_ADDR_BUS,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic                ice,
  input  logic [ADDR_W-1:0]   iaddr,
  output logic [DATA_W-1:0]   inst,
  output logic                inst_valid,
  input  logic                dce,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W/8-1:0] we,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dm,
  output logic                dm_valid,
  input  logic                flush,
  output logic                stallreq_arb,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  owner_t            owner_reg, owner_next;
  logic [DATA_W-1:0] inst_reg;
  logic [DATA_W-1:0] dm_reg;
  logic              grant_d, grant_i;

  assign grant_d = dce;
  assign grant_i = ice & ~dce;

  // Combinational outputs are forced low while reset is held, even with requests up
  always_comb begin
    ram_en       = 1'b0;
    ram_we       = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    stallreq_arb = 1'b0;
    owner_next   = OWN_IDLE;
    if (cpu_rst_n) begin
      ram_en       = ice | dce;
      stallreq_arb = ice & dce & ~flush;
      if (grant_d) begin
        ram_addr   = daddr;
        ram_we     = we;
        ram_wdata  = din;
        owner_next = (we != '0) ? OWN_DWRITE : OWN_DREAD;
      end else if (grant_i) begin
        ram_addr = iaddr;
        // A flushed fetch still reads the SRAM but its data is discarded
        if (!flush) begin
          owner_next = OWN_IFETCH;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      owner_reg <= OWN_IDLE;
      inst_reg  <= '0;
      dm_reg    <= '0;
    end else begin
      owner_reg <= owner_next;
      if (owner_reg == OWN_IFETCH) begin
        inst_reg <= ram_rdata;
      end
      if (owner_reg == OWN_DREAD) begin
        dm_reg <= ram_rdata;
      end
    end
  end

  assign inst       = (owner_reg == OWN_IFETCH) ? ram_rdata : inst_reg;
  assign dm         = (owner_reg == OWN_DREAD)  ? ram_rdata : dm_reg;
  assign inst_valid = (owner_reg == OWN_IFETCH);
  assign dm_valid   = (owner_reg == OWN_DREAD);

  sat_counter #(
    .W(CNT_W)
  ) u_conflict_cnt (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .inc   (ice & dce),
    .count (conflict_cnt)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table plus scoreboard of expected read responses.
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ice = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          dce = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [3:0]    we = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dm;
  logic          dm_valid;
  logic          flush = 1'b0;
  logic          stallreq_arb;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .ice         (ice),
    .iaddr       (iaddr),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .dce         (dce),
    .daddr       (daddr),
    .we          (we),
    .din         (din),
    .dm          (dm),
    .dm_valid    (dm_valid),
    .flush       (flush),
    .stallreq_arb(stallreq_arb),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] mem[0:255];
  logic [31:0] ref_mem[0:255];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  // Write-first synchronous SRAM with one-cycle read latency
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[4]  = 32'h2402_0001;
    mem[5]  = 32'h8C43_0000;
    mem[32] = 32'hDEAD_BEEF;
    mem[33] = 32'h0000_0055;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        mem[ram_addr[9:2]] <= merge(mem[ram_addr[9:2]], ram_wdata, ram_we);
        ram_rdata          <= merge(mem[ram_addr[9:2]], ram_wdata, ram_we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (inst_valid === 1'b1) begin
          if (exp_inst_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL inst_sb actual=unexpected_valid inst=0x%08h required=no_response", inst);
          end else begin
            chk("inst_sb", inst, exp_inst_q.pop_front());
          end
        end
        if (dm_valid === 1'b1) begin
          if (exp_dm_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dm_sb actual=unexpected_valid dm=0x%08h required=no_response", dm);
          end else begin
            chk("dm_sb", dm, exp_dm_q.pop_front());
          end
        end
      end
    end
  endtask

  // Drive one cycle of requests; when tracked, predict the response from the bench's own memory image
  task automatic drive(input logic i_ice, input logic [31:0] i_iaddr, input logic i_dce,
                       input logic [31:0] i_daddr, input logic [3:0] i_we, input logic [31:0] i_din,
                       input logic i_flush, input bit track);
    ice = i_ice; iaddr = i_iaddr; dce = i_dce; daddr = i_daddr;
    we = i_we; din = i_din; flush = i_flush;
    if (track) begin
      if (i_dce) begin
        if (i_we == 4'h0) exp_dm_q.push_back(ref_mem[i_daddr[9:2]]);
        else ref_mem[i_daddr[9:2]] = merge(ref_mem[i_daddr[9:2]], i_din, i_we);
      end else if (i_ice && !i_flush) begin
        exp_inst_q.push_back(ref_mem[i_iaddr[9:2]]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'h0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_stall"}, 32'(stallreq_arb), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_dm"}, dm, 32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_dm_valid"}, 32'(dm_valid), 32'h0);
    chk({tag, "_cnt"}, 32'(conflict_cnt), 32'h0);
  endtask

  typedef struct {
    logic        ice;   logic [31:0] iaddr;
    logic        dce;   logic [31:0] daddr;
    logic [3:0]  we;    logic [31:0] din;   logic flush;
    logic        en;    logic [3:0]  rwe;   logic [31:0] raddr;
    logic [31:0] rwdata; logic       stall;
    logic        iv;    logic        dv;
    logic [31:0] inst;  logic [31:0] dm;    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // ice, iaddr, dce, daddr, we, din, flush | en, ram_we, ram_addr, ram_wdata, stall | iv, dv, inst, dm, cnt
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 32'h0,  4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2402_0001, 32'h0, 4'd0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 32'h0,  4'h0, 32'h0, 1'b0,
                 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 32'h2402_0001, 32'h0, 4'd0};
    vecs[2]  = '{1'b0, 32'h0,  1'b1, 32'h80, 4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2402_0001, 32'hDEAD_BEEF, 4'd0};
    vecs[3]  = '{1'b1, 32'h14, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2402_0001, 32'hDEAD_BEEF, 4'd1};
    vecs[4]  = '{1'b1, 32'h14, 1'b0, 32'h0,  4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8C43_0000, 32'hDEAD_BEEF, 4'd1};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 32'h84, 4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h84, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8C43_0000, 32'h55, 4'd1};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 32'h80, 4'hF, 32'hAAAA_AAAA, 1'b0,
                 1'b1, 4'hF, 32'h80, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0, 32'h8C43_0000, 32'h55, 4'd1};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 32'h80, 4'h3, 32'h1234_5678, 1'b0,
                 1'b1, 4'h3, 32'h80, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h8C43_0000, 32'h55, 4'd1};
    vecs[8]  = '{1'b1, 32'h10, 1'b0, 32'h0,  4'h0, 32'h0, 1'b1,
                 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8C43_0000, 32'h55, 4'd1};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 32'h80, 4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8C43_0000, 32'hAAAA_5678, 4'd1};
    vecs[10] = '{1'b1, 32'h10, 1'b1, 32'h84, 4'h0, 32'h0, 1'b1,
                 1'b1, 4'h0, 32'h84, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8C43_0000, 32'h55, 4'd2};
    vecs[11] = '{1'b1, 32'h10, 1'b1, 32'h88, 4'hF, 32'hCAFE_F00D, 1'b0,
                 1'b1, 4'hF, 32'h88, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h8C43_0000, 32'h55, 4'd3};
    vecs[12] = '{1'b1, 32'h10, 1'b1, 32'h88, 4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h88, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8C43_0000, 32'hCAFE_F00D, 4'd4};
    vecs[13] = '{1'b1, 32'h10, 1'b0, 32'h0,  4'h0, 32'h0, 1'b0,
                 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2402_0001, 32'hCAFE_F00D, 4'd4};
    vecs[14] = '{1'b0, 32'h0,  1'b0, 32'h0,  4'h0, 32'h0, 1'b0,
                 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 32'h2402_0001, 32'hCAFE_F00D, 4'd4};

    for (int k = 0; k < 256; k++) ref_mem[k] = '0;
    ref_mem[4]  = 32'h2402_0001;
    ref_mem[5]  = 32'h8C43_0000;
    ref_mem[32] = 32'hDEAD_BEEF;
    ref_mem[33] = 32'h0000_0055;

    fork
      monitor();
    join_none

    // Reset with both requesters active: every output must stay 0
    drive(1'b1, 32'h10, 1'b1, 32'h80, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ice, vecs[i].iaddr, vecs[i].dce, vecs[i].daddr, vecs[i].we, vecs[i].din,
            vecs[i].flush, 1'b1);
      #2;
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].rwe));
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].raddr);
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].rwdata);
      chk($sformatf("v%0d_stall", i), 32'(stallreq_arb), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_dm_valid", i), 32'(dm_valid), 32'(vecs[i].dv));
      chk($sformatf("v%0d_inst", i), inst, vecs[i].inst);
      chk($sformatf("v%0d_dm", i), dm, vecs[i].dm);
      chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
    end

    // Reset in the middle of a load response
    drive(1'b0, 32'h0, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_dm_valid", 32'(dm_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_dm_valid", 32'(dm_valid), 32'h0);
    chk("post_rst_dm", dm, 32'h0);

    // Back-to-back conflicts: fetch starved, counter saturates at 15
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 32'h10, 1'b1, 32'h84, 4'h0, 32'h0, 1'b0, 1'b1);
      #2;
      chk($sformatf("sat%0d_stall", c), 32'(stallreq_arb), 32'h1);
      @(posedge clk);
      #1;
    end
    chk("sat_cnt", 32'(conflict_cnt), 32'd15);
    drive(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("starved_fetch_valid", 32'(inst_valid), 32'h1);
    chk("sat_hold_cnt", 32'(conflict_cnt), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_inst_drained", 32'(exp_inst_q.size()), 32'h0);
    chk("sb_dm_drained", 32'(exp_dm_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
